// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared defaults and width helper for mod_counter
package mod_counter_pkg;

  localparam int MOD_COUNTER_DEFAULT_MOD  = 24;
  localparam int MOD_COUNTER_DEFAULT_BITS = 5;

  // Smallest width that holds 0..n-1 (minimum 1), for deriving BITS from MOD.
  function automatic int mod_counter_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-MOD up-counter with terminal-count carry
// Optional checks compiled in with MOD_COUNTER_CHECK_EN.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int MOD  = MOD_COUNTER_DEFAULT_MOD,
  parameter int BITS = MOD_COUNTER_DEFAULT_BITS
) (
  input  logic            clk,
  input  logic            rst,
  output logic [BITS-1:0] count,
  output logic            carry
);

  localparam logic [BITS-1:0] TERM = BITS'(MOD - 1);

  logic [BITS-1:0] count_q;
  logic [BITS-1:0] count_d;

  // Terminal and out-of-range states both load zero on the next edge.
  always_comb begin
    count_d = '0;
    if (count_q < TERM) count_d = count_q + BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;
  assign carry = (count_q == TERM);

`ifdef MOD_COUNTER_CHECK_EN
  if (MOD < 2 || MOD > (1 << BITS)) begin : g_bad_params
    $error("mod_counter: MOD=%0d illegal for BITS=%0d", MOD, BITS);
  end

  a_in_range : assert property (@(posedge clk) rst |-> (int'(count_q) < MOD));
  a_carry    : assert property (@(posedge clk) carry == (count_q == TERM));
`else
  // Checks compiled out; datapath is identical.
`endif

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed bench for mod_counter at MOD=24, 10 and 16
module tb_mod_counter;
  import mod_counter_pkg::*;

  localparam int B10 = mod_counter_width(10);
  localparam int B16 = mod_counter_width(16);

  logic           clk;
  logic           rst;
  logic [4:0]     count24;
  logic           carry24;
  logic [B10-1:0] count10;
  logic           carry10;
  logic [B16-1:0] count16;
  logic           carry16;

  int n_asserts;
  int n_fails;

  mod_counter u_dut24 (.clk(clk), .rst(rst), .count(count24), .carry(carry24));
  mod_counter #(.MOD(10), .BITS(B10)) u_dut10 (.clk(clk), .rst(rst), .count(count10), .carry(carry10));
  mod_counter #(.MOD(16), .BITS(B16)) u_dut16 (.clk(clk), .rst(rst), .count(count16), .carry(carry16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_carry;
    int first_carry;
    int last_carry;
    int max_count;
    n_asserts   = 0;
    n_fails     = 0;
    n_carry     = 0;
    first_carry = -1;
    last_carry  = -1;
    max_count   = 0;

    rst = 1'b0;
    tick();
    check("reset_count24", count24, 0);
    check("reset_carry24", carry24, 0);
    check("reset_count10", count10, 0);
    check("reset_count16", count16, 0);

    rst = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      check("run_count24", count24, (i + 1) % 24);
      check("run_carry24", carry24, ((i + 1) % 24) == 23);
      check("run_count10", count10, (i + 1) % 10);
      check("run_carry10", carry10, ((i + 1) % 10) == 9);
      check("run_count16", count16, (i + 1) % 16);
      check("run_carry16", carry16, ((i + 1) % 16) == 15);
      if (int'(count24) > max_count) max_count = int'(count24);
      if (carry24) begin
        n_carry++;
        if (first_carry < 0) first_carry = i;
        last_carry = i;
      end
    end
    check("carry_pulses_48", n_carry, 2);
    check("carry_spacing", last_carry - first_carry, 24);
    check("max_count24", max_count, 23);

    for (int i = 0; i < 3; i++) tick();
    check("pre_reset_count", count24, 3);
    rst = 1'b0;
    tick();
    check("midreset_count", count24, 0);
    check("midreset_carry", carry24, 0);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("post_release_count", count24, i);
    end

    for (int i = 0; i < 20; i++) tick();
    check("at_term_count", count24, 23);
    check("at_term_carry", carry24, 1);
    rst = 1'b0;
    tick();
    check("carry_reset_count", count24, 0);
    check("carry_reset_carry", carry24, 0);
    rst = 1'b1;
    n_carry = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      check("restart_count", count24, i + 1);
      if (carry24) n_carry++;
    end
    check("no_extra_carry", n_carry, 0);
    tick();
    check("restart_term_count", count24, 23);
    check("restart_term_carry", carry24, 1);

    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    check("glitch_wrap_count", count24, 0);
    check("glitch_wrap_carry", carry24, 0);
    tick();
    check("glitch_next_count", count24, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

- Synchronous modulo-MOD up-counter with a terminal-count carry flag.
- Default configuration is MOD=24 in 5 bits, an hours-of-day counter that cascades into the day/date stage of the calendar datapath.
- Carry marks the final count of each cycle so the next stage can advance on the wrap.

## Interface
Parameters:
- MOD, 24, modulus; count sequence is 0..MOD-1; legal range 2..2^BITS.
- BITS, 5, width of count; must satisfy 2^BITS >= MOD.

Ports (positional order clk, rst, count, carry is fixed):
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-low: rst=0 sampled at a rising edge clears state.
- count  output  BITS  current count value, registered.
- carry  output  1  terminal-count flag, high while count == MOD-1.

## Operation
- No enable input: the counter advances on every rising clk edge with rst=1.
- Reset: at a rising edge with rst=0, count <= 0. Reset overrides counting. count=0 and carry=0 in the cycle following reset.
- Count: at a rising edge with rst=1:
  - count <= count+1 when count < MOD-1.
  - count <= 0 when count == MOD-1 (wrap).
- Carry: combinational decode of the count register.
  - carry = (count == MOD-1); no other condition drives it high.
  - Exactly one cycle high per MOD-cycle period.
  - Glitch-free because it decodes a single register compare.
- Out-of-range state: if count >= MOD (no reachable path, e.g. X/upset), the next enabled edge loads 0. carry stays 0 in that state.
- Arithmetic:
  - Increment is computed at BITS width.
  - Comparison constant MOD-1 is sized to BITS.
  - No overflow is possible when the legal range is respected.
- Before the first reset, count is undefined. Implementations must not rely on an initial value.

## Timing
- Latency: rst=0 takes effect at the first rising edge it is sampled. rst release takes effect at the first rising edge where rst=1 is sampled.
- Release from reset: after that first rst=1 edge, count=1.
- Carry timing:
  - carry rises in the same cycle count becomes MOD-1.
  - carry falls on the edge where count wraps to 0.
  - With the default parameters, carry is high for the 24th cycle of each 24-cycle period.
- Reset mid-count, including while carry=1: count=0 and carry=0 after that edge. The sequence restarts 0,1,2,… on release.
- Asynchronous rst glitches between edges have no effect.

## Configuration
- MOD_COUNTER_CHECK_EN defined:
  - Elaboration-time check fails if MOD < 2 or MOD > 2^BITS.
  - Simulation assertion flags any clock edge where rst=1 and count >= MOD.
  - Simulation assertion flags carry disagreeing with (count == MOD-1).
- MOD_COUNTER_CHECK_EN undefined: no checks are compiled. Functional behaviour is identical.

## Structure
- Shared package mod_counter_pkg:
  - Default constants MOD_COUNTER_DEFAULT_MOD=24 and MOD_COUNTER_DEFAULT_BITS=5.
  - Function clog2-style width helper for instantiators deriving BITS from MOD.
- No sub-module: a single count register, a next-state mux, and a compare. Cascaded stages (minutes→hours→days) are built by instantiating mod_counter repeatedly at the next level up.

## Test plan
- Reset then run, defaults: rst=0 for one edge then 1 -> count 0,1,…,23,0,1. carry=1 only when count=23.
- Wrap count over 48 cycles -> carry high for exactly 2 cycles, 24 cycles apart. count never exceeds 23.
- Mid-run reset: pulse rst=0 for one edge at count=3 -> count=0, carry=0. Next values 1,2,3 after release.
- Reset while carry=1 (count=23), rst=0 -> count=0 and carry=0 on that edge. No extra carry pulse.
- MOD=10, BITS=4 -> sequence 0..9 repeating. carry=1 at count=9 only.
- MOD=16, BITS=4, full binary range -> wrap 15->0 with carry=1 at 15. With MOD_COUNTER_CHECK_EN, MOD=40 with BITS=5 fails elaboration.
